// File: rtl/instruction_serializer_pkg.sv
// Shared constants and types for the nibble link between the serializer and the
// receive-side instruction buffer.
package instruction_serializer_pkg;

    localparam int INSTR_W = 20;
    localparam int NIB_W   = 4;
    localparam int NIBBLES = INSTR_W / NIB_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/instruction_serializer.sv
// Serializes instruction words into MSB-first nibbles. A one-word pending slot
// behind the shift register lets consecutive words stream with no idle cycle.
module instruction_serializer #(
    parameter int WORD_W = instruction_serializer_pkg::INSTR_W,
    parameter int NIB_W  = instruction_serializer_pkg::NIB_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_word,
    output logic              in_ready,
    output logic              nib_valid,
    output logic [NIB_W-1:0]  nib_data,
    output logic              nib_last,
    input  logic              nib_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  words_sent
);
    import instruction_serializer_pkg::*;

    localparam int N_NIB = WORD_W / NIB_W;
    localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIB - 1);

    ser_state_t        state_reg;
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] pend_reg;
    logic              pend_valid_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic shifting;
    logic accept;
    logic hs;
    logic at_last;

    assign shifting   = (state_reg == SHIFT);
    assign in_ready   = !rst && !flush && !pend_valid_reg;
    assign accept     = in_valid && in_ready;
    assign nib_valid  = !rst && shifting;
    assign hs         = nib_valid && nib_ready;
    assign at_last    = (idx_reg == LAST_IDX);
    assign nib_last   = nib_valid && at_last;
    // shift_reg is zeroed whenever the block goes idle, so only reset needs masking
    assign nib_data   = rst ? '0 : shift_reg[WORD_W-1 -: NIB_W];
    assign busy       = !rst && (shifting || pend_valid_reg);
    assign words_sent = cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            idx_reg        <= '0;
            cnt_reg        <= '0;
        end else begin
            // A final handshake coinciding with flush still completed its word
            if (hs && at_last) begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (flush) begin
                state_reg      <= IDLE;
                shift_reg      <= '0;
                pend_valid_reg <= 1'b0;
                idx_reg        <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            shift_reg <= in_word;
                            idx_reg   <= '0;
                            state_reg <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (hs && at_last) begin
                            // Refill from pend first; in_ready is low whenever pend is full
                            if (pend_valid_reg) begin
                                shift_reg      <= pend_reg;
                                pend_valid_reg <= 1'b0;
                                idx_reg        <= '0;
                            end else if (accept) begin
                                shift_reg <= in_word;
                                idx_reg   <= '0;
                            end else begin
                                state_reg <= IDLE;
                                shift_reg <= '0;
                                idx_reg   <= '0;
                            end
                        end else begin
                            if (hs) begin
                                shift_reg <= shift_reg << NIB_W;
                                idx_reg   <= idx_reg + 1'b1;
                            end
                            if (accept) begin
                                pend_reg       <= in_word;
                                pend_valid_reg <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/instruction_serializer.md
Name: instruction_serializer

Overview:
- Transmit-side counterpart of the nibble-assembling instruction buffer.
- Accepts complete 20-bit instruction words over a valid/ready handshake and emits them as 4-bit nibbles, MSB nibble first, over a second valid/ready handshake.
- Sits between the instruction/frame generator and the nibble-wide link or FIFO that feeds the player's receive buffer.
- Double-buffered (shift register plus one pending word), so back-to-back words stream without bubbles.

Parameters:
- WORD_W, 20: instruction width in bits; must be an integer multiple of NIB_W.
- NIB_W, 4: nibble width in bits.
- CNT_W, 16: width of the sent-word counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of the shift register, pending word and nibble index; the counter is kept.
- in_valid  in  1  in_word is valid.
- in_word  in  WORD_W  instruction to serialize.
- in_ready  out  1  block can accept in_word this cycle.
- nib_valid  out  1  nib_data is valid.
- nib_data  out  NIB_W  current nibble, the top NIB_W bits of the shift register.
- nib_last  out  1  nib_data is the final nibble of its word.
- nib_ready  in  1  downstream accepts the nibble.
- busy  out  1  shift register or pending slot is occupied.
- words_sent  out  CNT_W  count of fully transmitted words; wraps modulo 2^CNT_W.

Behaviour:
- Derived constant: NIBBLES = WORD_W/NIB_W, which is 5 by default. Index idx width is clog2(NIBBLES).
- States:
  - IDLE: shift register empty.
  - SHIFT: shift register holds a word.
- Reset (rst=1), effective on the next edge: state=IDLE, shift_reg=0, pend_valid=0, idx=0, words_sent=0.
  - While rst is high, outputs are nib_valid=0, nib_data=0, nib_last=0, busy=0, in_ready=0.
  - A reset mid-word discards the partial word with no further nibbles.
- in_ready = !rst && !flush && !pend_valid. This is combinational.
- Input accept = in_valid && in_ready.
- Nibble handshake hs = nib_valid && nib_ready.
- Output decode:
  - nib_valid = (state==SHIFT).
  - nib_last = nib_valid && (idx==NIBBLES-1).
  - busy = (state==SHIFT) || pend_valid.
- IDLE:
  - On accept, load shift_reg=in_word, idx=0, go to SHIFT.
  - Latency: a word accepted at edge N presents its first nibble in the cycle after N.
- SHIFT, hs when not last: shift_reg <<= NIB_W with zero fill, idx++.
- SHIFT, no hs: shift_reg, idx and nib_data hold stable; backpressure never drops or repeats a nibble.
- SHIFT, hs on the last nibble:
  - words_sent++.
  - If pend_valid: load shift_reg from pend, clear pend_valid, idx=0, stay in SHIFT.
  - Else if accept in the same cycle: load in_word directly into shift_reg, idx=0, stay in SHIFT. No bubble.
  - Else: go to IDLE, shift_reg=0.
- SHIFT, accept when not (last && hs && pending empty): word goes to pend, pend_valid=1.
- Pending full: in_ready=0 until the current word's last nibble handshake.
  - Pend refills the shift register on that edge.
  - in_ready returns to 1 in the following cycle.
- flush (rst has priority over flush):
  - Effective on the next edge: IDLE, shift_reg=0, pend_valid=0, idx=0.
  - words_sent is unchanged.
  - A last-nibble hs in the same cycle as flush still counts.
  - in_ready=0 during the flush cycle.
- words_sent wraps from 2^CNT_W-1 to 0.
- Maximum throughput is one nibble per cycle when nib_ready is held at 1.

Decomposition:
- Shared package holds:
  - INSTR_W=20 and NIB_W=4 (also used by the receive buffer).
  - NIBBLES.
  - A state enum {IDLE, SHIFT}.
- No sub-module. A one-entry pending register is inline logic, not worth a separate FIFO.

Test Plan:
- Single word, ready high: in_word=0xABCDE accepted at cycle 0 -> nib_data A,B,C,D,E on cycles 1-5. nib_last=1 only on E. words_sent=1. nib_valid=0 on cycle 6.
- Back-to-back, in_valid held: 0x12345 then 0x6789A with nib_ready=1 -> 10 consecutive nibbles 1..9,A with no nib_valid gap. nib_last on 5 and A. words_sent=2.
- Backpressure: send 0xABCDE and drop nib_ready for 3 cycles while nib_data=C -> C held stable for 4 cycles. Sequence is exactly A,B,C,D,E.
- Pending full: nib_ready=0, offer three words -> first loads, second pends, in_ready=0 for the third. After five handshakes, the third word is accepted the cycle after the second word is loaded.
- Flush mid-word: flush after nibbles 1,2 of 0x12345 with a word pending -> no further nibbles, busy=0, in_ready=1 the next cycle. The next word 0xFEDCB serializes correctly.
- Reset/wrap: force words_sent to 0xFFFF via 65535 words and send one more -> words_sent=0. Assert rst mid-word -> all outputs 0, state IDLE.
